// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with a two-entry skid buffer.
// The main entry drives the execute-stage ALU operands directly; the skid
// entry absorbs the single word that decode may push in the cycle execute
// stalls, so IN_READY can be a pure register with no path from OUT_READY.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_EMPTY | neither entry valid, OUT_VALID=0, IN_READY=1
// S_ONE   | main entry valid (drives OUT_*), skid empty, IN_READY=1
// S_FULL  | main and skid valid, IN_READY=0
module id_ex_skid_reg #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] IN_PC,
  input  logic [XLEN-1:0] IN_RS1_DATA,
  input  logic [XLEN-1:0] IN_RS2_DATA,
  input  logic [XLEN-1:0] IN_IMM,
  input  logic            IN_ALU_SRC,
  input  logic [2:0]      IN_ALU_CONTROL,
  input  logic [RD_W-1:0] IN_RD,
  input  logic            IN_REG_WRITE,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_PC,
  output logic [XLEN-1:0] OUT_A,
  output logic [XLEN-1:0] OUT_B,
  output logic [XLEN-1:0] OUT_RS2_DATA,
  output logic [2:0]      OUT_ALU_CONTROL,
  output logic [RD_W-1:0] OUT_RD,
  output logic            OUT_REG_WRITE
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2;
    logic [2:0]      alu_ctl;
    logic [RD_W-1:0] rd;
    logic            reg_write;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t in_entry;
  logic   accept;
  logic   fire;

  // Pack the incoming decode word; the B operand mux is resolved here so the
  // ALU sees a plain register on both operands.
  always_comb begin
    in_entry           = '0;
    in_entry.pc        = IN_PC;
    in_entry.a         = IN_RS1_DATA;
    in_entry.b         = IN_ALU_SRC ? IN_IMM : IN_RS2_DATA;
    in_entry.rs2       = IN_RS2_DATA;
    in_entry.alu_ctl   = IN_ALU_CONTROL;
    in_entry.rd        = IN_RD;
    in_entry.reg_write = IN_REG_WRITE;
  end

  assign accept = IN_VALID & in_ready_q;
  assign fire   = (state_q != S_EMPTY) & OUT_READY;

  // Next-state and entry movement; flush clears payloads so a killed
  // instruction cannot leak operands to execute.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && fire) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = S_FULL;
          end else if (fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Ready is computed from the next state so it is a flop output, never a
  // combinational function of OUT_READY.
  assign in_ready_d = (state_d != S_FULL);

  // State, payload and ready registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign IN_READY        = in_ready_q;
  assign OUT_VALID       = (state_q != S_EMPTY);
  assign OUT_PC          = main_q.pc;
  assign OUT_A           = main_q.a;
  assign OUT_B           = main_q.b;
  assign OUT_RS2_DATA    = main_q.rs2;
  assign OUT_ALU_CONTROL = main_q.alu_ctl;
  assign OUT_RD          = main_q.rd;
  // A stale payload must never trigger a writeback.
  assign OUT_REG_WRITE   = OUT_VALID & main_q.reg_write;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Self-checking bench for id_ex_skid_reg: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_id_ex_skid_reg;

  localparam logic [2:0] ALU_ADD = 3'b000;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_PC;
  logic [31:0] IN_RS1_DATA;
  logic [31:0] IN_RS2_DATA;
  logic [31:0] IN_IMM;
  logic        IN_ALU_SRC;
  logic [2:0]  IN_ALU_CONTROL;
  logic [4:0]  IN_RD;
  logic        IN_REG_WRITE;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_A;
  logic [31:0] OUT_B;
  logic [31:0] OUT_RS2_DATA;
  logic [2:0]  OUT_ALU_CONTROL;
  logic [4:0]  OUT_RD;
  logic        OUT_REG_WRITE;

  id_ex_skid_reg #(.XLEN(32), .RD_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PC(IN_PC), .IN_RS1_DATA(IN_RS1_DATA), .IN_RS2_DATA(IN_RS2_DATA),
    .IN_IMM(IN_IMM), .IN_ALU_SRC(IN_ALU_SRC), .IN_ALU_CONTROL(IN_ALU_CONTROL),
    .IN_RD(IN_RD), .IN_REG_WRITE(IN_REG_WRITE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_RS2_DATA(OUT_RS2_DATA),
    .OUT_ALU_CONTROL(OUT_ALU_CONTROL), .OUT_RD(OUT_RD), .OUT_REG_WRITE(OUT_REG_WRITE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
  } word_t;

  // Reference model: an in-order queue of at most two words plus the
  // payload last shown on the output (held while nothing is valid).
  word_t q[$];
  word_t last_w;
  logic  acc_last;
  int    checks;
  int    errors;

  function automatic word_t cur_word();
    word_t w;
    w.pc  = IN_PC;
    w.a   = IN_RS1_DATA;
    w.b   = IN_ALU_SRC ? IN_IMM : IN_RS2_DATA;
    w.rs2 = IN_RS2_DATA;
    w.op  = IN_ALU_CONTROL;
    w.rd  = IN_RD;
    w.rw  = IN_REG_WRITE;
    return w;
  endfunction

  task automatic model_update();
    int n;
    logic fire;
    logic acc;
    acc_last = 1'b0;
    if (RESET || FLUSH) begin
      q.delete();
      last_w = '0;
    end else begin
      n    = q.size();
      fire = (n > 0) && OUT_READY;
      acc  = IN_VALID && (n < 2);
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(cur_word());
      if (q.size() > 0) last_w = q[0];
      acc_last = acc;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    word_t e;
    logic  v;
    v = (q.size() > 0);
    e = v ? q[0] : last_w;
    chk("out_valid", {31'd0, OUT_VALID}, {31'd0, v});
    chk("in_ready", {31'd0, IN_READY}, {31'd0, q.size() < 2});
    chk("out_pc", OUT_PC, e.pc);
    chk("out_a", OUT_A, e.a);
    chk("out_b", OUT_B, e.b);
    chk("out_rs2", OUT_RS2_DATA, e.rs2);
    chk("out_op", {29'd0, OUT_ALU_CONTROL}, {29'd0, e.op});
    chk("out_rd", {27'd0, OUT_RD}, {27'd0, e.rd});
    chk("out_rw", {31'd0, OUT_REG_WRITE}, {31'd0, v & e.rw});
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic src,
                       input logic [2:0] op, input logic [4:0] rd, input logic rw);
    IN_VALID       = v;
    IN_PC          = pc;
    IN_RS1_DATA    = rs1;
    IN_RS2_DATA    = rs2;
    IN_IMM         = imm;
    IN_ALU_SRC     = src;
    IN_ALU_CONTROL = op;
    IN_RD          = rd;
    IN_REG_WRITE   = rw;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, $urandom, $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom % 5),
          5'($urandom), 1'($urandom));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_w   = '0;
    acc_last = 1'b0;
    RESET    = 1'b1;
    FLUSH    = 1'b0;
    OUT_READY = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 5'd0, 1'b0);

    // Reset state
    step();
    step();
    RESET = 1'b0;
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("rst_out_a", OUT_A, 32'd0);

    // Back-to-back stream with OUT_READY high: one word per cycle
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 5'(i + 1), 1'b1);
      step();
      chk("stream_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("stream_a", OUT_A, 32'd5);
      chk("stream_b", OUT_B, 32'd7);
      chk("stream_pc", OUT_PC, 32'h100 + 32'(4 * i));
    end

    // Immediate select for operand B
    drive(1'b1, 32'h200, 32'd1, 32'h11, 32'hFFFF_FFFC, 1'b1, ALU_ADD, 5'd9, 1'b1);
    step();
    chk("imm_b", OUT_B, 32'hFFFF_FFFC);
    chk("imm_rs2", OUT_RS2_DATA, 32'h11);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 5'd0, 1'b0);
    step();
    chk("drain_rw", {31'd0, OUT_REG_WRITE}, 32'd0);

    // Backpressure: W0 in main, W1 in skid, W2 held until released
    OUT_READY = 1'b0;
    drive(1'b1, 32'h300, 32'hA0, 32'hB0, 32'h0, 1'b0, 3'd1, 5'd1, 1'b1);
    step();
    drive(1'b1, 32'h304, 32'hA1, 32'hB1, 32'h0, 1'b0, 3'd2, 5'd2, 1'b1);
    step();
    chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
    chk("bp_main_pc", OUT_PC, 32'h300);
    drive(1'b1, 32'h308, 32'hA2, 32'hB2, 32'h0, 1'b0, 3'd3, 5'd3, 1'b1);
    step();
    step();
    chk("bp_hold_pc", OUT_PC, 32'h300);
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc_last) IN_VALID = 1'b0;
    end
    chk("bp_drained", {31'd0, OUT_VALID}, 32'd0);

    // Flush while FULL drops both entries and the offered word
    OUT_READY = 1'b0;
    drive(1'b1, 32'h400, 32'hC0, 32'hD0, 32'h0, 1'b0, 3'd4, 5'd4, 1'b1);
    step();
    drive(1'b1, 32'h404, 32'hC1, 32'hD1, 32'h0, 1'b0, 3'd4, 5'd5, 1'b1);
    step();
    drive(1'b1, 32'h408, 32'hC2, 32'hD2, 32'h0, 1'b0, 3'd4, 5'd6, 1'b1);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    chk("fl_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("fl_rw", {31'd0, OUT_REG_WRITE}, 32'd0);
    chk("fl_a", OUT_A, 32'd0);
    chk("fl_ready", {31'd0, IN_READY}, 32'd1);
    OUT_READY = 1'b1;
    step();
    step();

    // Reset in FULL with OUT_READY toggling, then a fresh word
    OUT_READY = 1'b0;
    drive(1'b1, 32'h500, 32'hE0, 32'hF0, 32'h0, 1'b0, 3'd0, 5'd7, 1'b1);
    step();
    drive(1'b1, 32'h504, 32'hE1, 32'hF1, 32'h0, 1'b0, 3'd0, 5'd8, 1'b1);
    step();
    OUT_READY = 1'b1;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    OUT_READY = 1'b0;
    chk("mrst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("mrst_pc", OUT_PC, 32'd0);
    chk("mrst_ready", {31'd0, IN_READY}, 32'd1);
    drive(1'b1, 32'h600, 32'h66, 32'h77, 32'h0, 1'b0, ALU_ADD, 5'd10, 1'b1);
    step();
    IN_VALID = 1'b0;
    chk("mrst_lat_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("mrst_lat_a", OUT_A, 32'h66);

    // Randomized traffic; decode holds its word until it is taken
    drive_rand(1'b1);
    for (int i = 0; i < 1000; i++) begin
      OUT_READY = ($urandom % 3) != 0;
      FLUSH     = ($urandom % 97) == 0;
      RESET     = ($urandom % 331) == 0;
      step();
      FLUSH = 1'b0;
      RESET = 1'b0;
      if (acc_last || !IN_VALID) drive_rand(($urandom % 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Decode-to-execute pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Captures decoded operands and control, selects the ALU B operand (immediate or rs2), and presents A/B/ALU_CONTROL directly to the execute-stage ALU.
- Full throughput when the downstream stage is ready; absorbs one extra word when execute stalls.
- Flush input kills in-flight instructions on branch redirect.

Parameters:
XLEN, 32, datapath width; must equal INST_SIZE.
RD_W, 5, destination register index width.

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
FLUSH  in  1  kill all buffered entries and any same-cycle input
IN_VALID  in  1  decode presents a valid instruction
IN_READY  out  1  block can accept this cycle
IN_PC  in  XLEN  instruction PC
IN_RS1_DATA  in  XLEN  rs1 operand
IN_RS2_DATA  in  XLEN  rs2 operand
IN_IMM  in  XLEN  sign-extended immediate
IN_ALU_SRC  in  1  1: B = IMM; 0: B = RS2_DATA
IN_ALU_CONTROL  in  3  ALU opcode (ALU_ADD/SUB/AND/OR/XOR encodings)
IN_RD  in  RD_W  destination register
IN_REG_WRITE  in  1  writeback enable
OUT_VALID  out  1  execute-side payload valid
OUT_READY  in  1  execute stage consumes this cycle
OUT_PC  out  XLEN  PC
OUT_A  out  XLEN  ALU operand A (rs1)
OUT_B  out  XLEN  ALU operand B (muxed at capture)
OUT_RS2_DATA  out  XLEN  store data
OUT_ALU_CONTROL  out  3  ALU opcode
OUT_RD  out  RD_W  destination register
OUT_REG_WRITE  out  1  writeback enable, gated: 0 whenever OUT_VALID=0

Behaviour:
- State: main entry (drives OUT_*) and skid entry, each with a valid bit. States: EMPTY (neither valid), ONE (main only), FULL (main + skid). Skid valid without main valid is illegal.
- IN_READY = !skid_valid, registered (no combinational path from OUT_READY). In EMPTY/ONE, IN_READY=1; in FULL, IN_READY=0.
- Input accept: IN_VALID & IN_READY. Output fire: OUT_VALID & OUT_READY.
- Capture: OUT_B latched as IN_ALU_SRC ? IN_IMM : IN_RS2_DATA. Other fields are copied unchanged. No arithmetic is performed.
- Latency: accepted word appears on OUT_* the next cycle when main is free or firing. Throughput is 1/cycle with OUT_READY held high.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + fire -> ONE; main reloads from input.
  - ONE + accept + no fire -> FULL; input goes to skid.
  - ONE + fire, no accept -> EMPTY.
  - FULL + fire -> ONE; skid moves to main.
  - FULL + no fire -> FULL; hold.
- Ordering is strictly FIFO. While OUT_VALID=1 and OUT_READY=0, all OUT_* are stable.
- IN_VALID while IN_READY=0 is ignored; decode must hold its payload.
- FLUSH (priority below RESET, above everything else): next cycle both valid bits are 0, all payload fields are 0, and IN_READY=1. Input offered in the flush cycle is dropped. A fire in the flush cycle still counts as consumed by execute.
- RESET: next edge sets all OUT_* = 0, OUT_VALID=0, IN_READY=1, state EMPTY. A reset mid-transfer discards everything.
- When not valid and not reset/flushed, payload holds its last value, except OUT_REG_WRITE, which reads 0.

Test Plan:
- Reset then stream: after RESET, OUT_VALID=0, IN_READY=1. Send 3 words (ADD, ALU_SRC=0, RS1=5, RS2=7) back-to-back with OUT_READY=1 -> each appears 1 cycle later with A=5, B=7, one per cycle, no bubbles.
- Immediate select: IN_ALU_SRC=1, IMM=0xFFFFFFFC, RS2=0x11 -> OUT_B=0xFFFFFFFC, OUT_RS2_DATA=0x11.
- Backpressure: OUT_READY=0 while sending W0, W1, W2 on consecutive cycles -> W0 on output, W1 in skid, IN_READY drops to 0 the cycle after W1 is accepted, W2 held. Release OUT_READY -> W0, W1, W2 emerge in order, nothing lost or duplicated.
- Flush in FULL: W0 in main, W1 in skid, W2 offered, FLUSH=1 -> next cycle OUT_VALID=0, OUT_REG_WRITE=0, OUT_A=0, IN_READY=1. W2 never appears.
- Reset mid-operation: RESET asserted in FULL with OUT_READY toggling -> next cycle all outputs 0, state EMPTY. A subsequent word passes with 1-cycle latency.
- Hold stability: randomize OUT_READY for 1000 cycles -> OUT_* never change while OUT_VALID=1 and OUT_READY=0. The output sequence matches the input sequence exactly.
